// File: rtl/cnn_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cnn_pkg
// Brief    : DRAM map, address field widths, FSM encodings and signed max
//            shared by the CNN layer stages.
// Revision : 1.0 - initial release
// ============================================================================
package cnn_pkg;

    localparam int c_DRAM_IFMAP_BASE = 4096;
    localparam int c_DRAM_OFMAP_BASE = 8192;

    localparam int c_CHNL_BITS    = 4;
    localparam int c_ROW_BITS     = 5;
    localparam int c_COL_BITS     = 5;
    localparam int c_MAP_OFF_BITS = c_CHNL_BITS + c_ROW_BITS + c_COL_BITS;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RD   = 2'd1;
    localparam logic [1:0] c_ST_WR   = 2'd2;
    localparam logic [1:0] c_ST_DONE = 2'd3;

    // Callers sign-extend narrower words into this width and slice the result.
    localparam int c_SMAX_W = 64;

    function automatic logic signed [c_SMAX_W-1:0] smax(
        input logic signed [c_SMAX_W-1:0] a,
        input logic signed [c_SMAX_W-1:0] b
    );
        return (b > a) ? b : a;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pool_layer_if.sv
`default_nettype none
// ============================================================================
// Module   : pool_layer_if
// Brief    : Single-port DRAM read/write bus used by the pooling stage.
// Revision : 1.0 - initial release
// ============================================================================
interface pool_layer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 18
);
    logic                  dram_valid;
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic [ADDR_WIDTH-1:0] addr_in;
    logic [ADDR_WIDTH-1:0] addr_out;
    logic                  dram_en_wr;
    logic                  dram_en_rd;

    modport master (
        input  dram_valid, data_in,
        output data_out, addr_in, addr_out, dram_en_wr, dram_en_rd
    );

    modport slave (
        output dram_valid, data_in,
        input  data_out, addr_in, addr_out, dram_en_wr, dram_en_rd
    );
endinterface
`default_nettype wire

// File: rtl/pool_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : pool_addr_gen
// Brief    : Window/offset counters and read/write address formation for the
//            2x2 stride-2 pooling stage.
// Revision : 1.0 - initial release
// ============================================================================
module pool_addr_gen
    import cnn_pkg::*;
#(
    parameter int ADDR_WIDTH   = 18,
    parameter int IFMAP_BASE   = c_DRAM_IFMAP_BASE,
    parameter int OFMAP_BASE   = c_DRAM_OFMAP_BASE,
    parameter int IFMAP_WIDTH  = 28,
    parameter int IFMAP_HEIGHT = 28,
    parameter int NUM_CHNL     = 6
) (
    input  wire logic                  clk,
    input  wire logic                  srst,
    input  wire logic                  i_step_d,
    input  wire logic                  i_step_win,
    output logic [1:0]                 o_d,
    output logic                       o_last_d,
    output logic                       o_last_win,
    output logic [ADDR_WIDTH-1:0]      o_addr_rd,
    output logic [ADDR_WIDTH-1:0]      o_addr_wr
);

    localparam logic [c_COL_BITS-1:0]  c_PX_LAST  = c_COL_BITS'(IFMAP_WIDTH / 2 - 1);
    localparam logic [c_ROW_BITS-1:0]  c_PY_LAST  = c_ROW_BITS'(IFMAP_HEIGHT / 2 - 1);
    localparam logic [c_CHNL_BITS-1:0] c_C_LAST   = c_CHNL_BITS'(NUM_CHNL - 1);
    localparam logic [ADDR_WIDTH-1:0]  c_IF_BASE  = ADDR_WIDTH'(IFMAP_BASE);
    localparam logic [ADDR_WIDTH-1:0]  c_OF_BASE  = ADDR_WIDTH'(OFMAP_BASE);

    logic [1:0]               r_d;
    logic [c_COL_BITS-1:0]    r_px;
    logic [c_ROW_BITS-1:0]    r_py;
    logic [c_CHNL_BITS-1:0]   r_c;
    logic                     w_px_wrap;
    logic                     w_py_wrap;
    logic                     w_c_last;
    logic [c_MAP_OFF_BITS-1:0] w_rd_off;
    logic [c_MAP_OFF_BITS-1:0] w_wr_off;

    assign w_px_wrap = (r_px == c_PX_LAST);
    assign w_py_wrap = (r_py == c_PY_LAST);
    assign w_c_last  = (r_c == c_C_LAST);

    always_ff @(posedge clk) begin
        if (srst) begin
            r_d  <= '0;
            r_px <= '0;
            r_py <= '0;
            r_c  <= '0;
        end else begin
            if (i_step_d) begin
                r_d <= r_d + 2'd1;
            end
            if (i_step_win) begin
                if (w_px_wrap) begin
                    r_px <= '0;
                    if (w_py_wrap) begin
                        r_py <= '0;
                        r_c  <= w_c_last ? '0 : r_c + 4'd1;
                    end else begin
                        r_py <= r_py + 5'd1;
                    end
                end else begin
                    r_px <= r_px + 5'd1;
                end
            end
        end
    end

    assign o_d        = r_d;
    assign o_last_d   = (r_d == 2'd3);
    assign o_last_win = w_px_wrap && w_py_wrap && w_c_last;

    // d[0] is dx and d[1] is dy, so 2*p+offset is just the offset in the LSB.
    assign w_rd_off = {r_c, r_py[c_ROW_BITS-2:0], r_d[1], r_px[c_COL_BITS-2:0], r_d[0]};
    assign w_wr_off = {r_c, r_py, r_px};

    assign o_addr_rd = c_IF_BASE + ADDR_WIDTH'(w_rd_off);
    assign o_addr_wr = c_OF_BASE + ADDR_WIDTH'(w_wr_off);

endmodule
`default_nettype wire

// File: rtl/pool_layer.sv
`default_nettype none
// ============================================================================
// Module   : pool_layer
// Brief    : 2x2 stride-2 signed max-pooling with optional ReLU over a DRAM
//            resident feature map.
// Revision : 1.0 - initial release
// ============================================================================
module pool_layer
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 18,
    parameter int IFMAP_BASE   = c_DRAM_IFMAP_BASE,
    parameter int OFMAP_BASE   = c_DRAM_OFMAP_BASE,
    parameter int IFMAP_WIDTH  = 28,
    parameter int IFMAP_HEIGHT = 28,
    parameter int NUM_CHNL     = 6,
    parameter int RELU         = 1
) (
    input  wire logic         clk,
    input  wire logic         srst,
    input  wire logic         enable,
    output logic              done,
    pool_layer_if.master      dram
);

    localparam int c_EXT_W = c_SMAX_W - DATA_WIDTH;

    function automatic logic [DATA_WIDTH-1:0] smax_dw(
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b
    );
        logic signed [c_SMAX_W-1:0] res;
        res = smax({{c_EXT_W{a[DATA_WIDTH-1]}}, a}, {{c_EXT_W{b[DATA_WIDTH-1]}}, b});
        return res[DATA_WIDTH-1:0];
    endfunction

    logic [1:0]            r_state;
    logic [1:0]            w_next;
    logic [1:0]            w_d;
    logic                  w_last_d;
    logic                  w_last_win;
    logic                  w_step_d;
    logic                  w_step_win;
    logic [ADDR_WIDTH-1:0] w_addr_rd;
    logic [ADDR_WIDTH-1:0] w_addr_wr;
    logic [DATA_WIDTH-1:0] r_mx;
    logic [DATA_WIDTH-1:0] w_first;
    logic [DATA_WIDTH-1:0] w_win_max;
    logic                  w_unused_valid;

    assign w_step_d   = (r_state == c_ST_RD);
    assign w_step_win = (r_state == c_ST_WR);

    pool_addr_gen #(
        .ADDR_WIDTH   (ADDR_WIDTH),
        .IFMAP_BASE   (IFMAP_BASE),
        .OFMAP_BASE   (OFMAP_BASE),
        .IFMAP_WIDTH  (IFMAP_WIDTH),
        .IFMAP_HEIGHT (IFMAP_HEIGHT),
        .NUM_CHNL     (NUM_CHNL)
    ) u_addr_gen (
        .clk        (clk),
        .srst       (srst),
        .i_step_d   (w_step_d),
        .i_step_win (w_step_win),
        .o_d        (w_d),
        .o_last_d   (w_last_d),
        .o_last_win (w_last_win),
        .o_addr_rd  (w_addr_rd),
        .o_addr_wr  (w_addr_wr)
    );

    always_ff @(posedge clk) begin
        if (srst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_ST_IDLE: w_next = enable ? c_ST_RD : c_ST_IDLE;
            c_ST_RD:   w_next = w_last_d ? c_ST_WR : c_ST_RD;
            c_ST_WR:   w_next = w_last_win ? c_ST_DONE : c_ST_RD;
            c_ST_DONE: w_next = c_ST_IDLE;
            default:   w_next = c_ST_IDLE;
        endcase
    end

    // ReLU is folded into the first sample so the later maxes keep the floor.
    assign w_first   = (RELU != 0) ? smax_dw('0, dram.data_in) : dram.data_in;
    assign w_win_max = smax_dw(r_mx, dram.data_in);

    always_ff @(posedge clk) begin
        if (srst) begin
            r_mx <= '0;
        end else if (r_state == c_ST_RD) begin
            if (w_d == 2'd1) begin
                r_mx <= w_first;
            end else if (w_d != 2'd0) begin
                r_mx <= w_win_max;
            end
        end
    end

    always_comb begin
        dram.data_out   = '0;
        dram.addr_in    = '0;
        dram.addr_out   = '0;
        dram.dram_en_wr = 1'b0;
        dram.dram_en_rd = 1'b0;
        done            = 1'b0;
        case (r_state)
            c_ST_RD: begin
                dram.dram_en_rd = 1'b1;
                dram.addr_in    = w_addr_rd;
            end
            c_ST_WR: begin
                dram.dram_en_wr = 1'b1;
                dram.addr_out   = w_addr_wr;
                dram.data_out   = w_win_max;
            end
            c_ST_DONE: begin
                done = 1'b1;
            end
            default: begin
                done = 1'b0;
            end
        endcase
    end

    assign w_unused_valid = dram.dram_valid;

endmodule
`default_nettype wire

// File: tb/tb_pool_layer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pool_layer
// Brief    : Scoreboard bench for pool_layer: small-window, ReLU, extremes,
//            full default pass, mid-pass reset and busy enable.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pool_layer;

    typedef struct {
        logic [17:0] a;
        logic [31:0] d;
    } wr_t;

    logic clk = 1'b0;
    logic srst;
    logic en_s, en_r, en_f;
    logic done_s, done_r, done_f;

    int cyc        = 0;
    int checks     = 0;
    int errors     = 0;
    int wr_cnt_f   = 0;
    int rdwr_cnt_f = 0;

    logic [31:0] mem_s [0:32767];
    logic [31:0] mem_r [0:32767];
    logic [31:0] mem_f [0:32767];
    logic [31:0] rd_s, rd_r, rd_f;

    wr_t q_s[$];
    wr_t q_r[$];
    wr_t q_f[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pool_layer_if #(.DATA_WIDTH(32), .ADDR_WIDTH(18)) if_s ();
    pool_layer_if #(.DATA_WIDTH(32), .ADDR_WIDTH(18)) if_r ();
    pool_layer_if #(.DATA_WIDTH(32), .ADDR_WIDTH(18)) if_f ();

    assign if_s.dram_valid = 1'b0;
    assign if_r.dram_valid = 1'b0;
    assign if_f.dram_valid = 1'b0;
    assign if_s.data_in    = rd_s;
    assign if_r.data_in    = rd_r;
    assign if_f.data_in    = rd_f;

    // Read data returns one cycle after the strobe.
    always @(posedge clk) begin
        if (if_s.dram_en_rd === 1'b1) rd_s <= mem_s[if_s.addr_in[14:0]];
        if (if_r.dram_en_rd === 1'b1) rd_r <= mem_r[if_r.addr_in[14:0]];
        if (if_f.dram_en_rd === 1'b1) rd_f <= mem_f[if_f.addr_in[14:0]];
    end

    pool_layer #(.DATA_WIDTH(32), .ADDR_WIDTH(18), .IFMAP_BASE(4096), .OFMAP_BASE(8192),
                 .IFMAP_WIDTH(2), .IFMAP_HEIGHT(2), .NUM_CHNL(1), .RELU(0))
        u_s (.clk(clk), .srst(srst), .enable(en_s), .done(done_s), .dram(if_s));

    pool_layer #(.DATA_WIDTH(32), .ADDR_WIDTH(18), .IFMAP_BASE(4096), .OFMAP_BASE(8192),
                 .IFMAP_WIDTH(2), .IFMAP_HEIGHT(2), .NUM_CHNL(1), .RELU(1))
        u_r (.clk(clk), .srst(srst), .enable(en_r), .done(done_r), .dram(if_r));

    pool_layer #(.DATA_WIDTH(32), .ADDR_WIDTH(18), .IFMAP_BASE(4096), .OFMAP_BASE(8192),
                 .IFMAP_WIDTH(28), .IFMAP_HEIGHT(28), .NUM_CHNL(6), .RELU(1))
        u_f (.clk(clk), .srst(srst), .enable(en_f), .done(done_f), .dram(if_f));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic int rd_idx(input int c, input int y, input int x);
        return 4096 + c * 1024 + y * 32 + x;
    endfunction

    function automatic logic [31:0] gold(input int c, input int py, input int px);
        logic signed [31:0] m;
        logic signed [31:0] v;
        m = mem_f[15'(rd_idx(c, 2 * py, 2 * px))];
        for (int k = 1; k < 4; k++) begin
            v = mem_f[15'(rd_idx(c, 2 * py + k / 2, 2 * px + k % 2))];
            if (v > m) m = v;
        end
        if (m < 0) m = 0;
        return m;
    endfunction

    // Monitor: every write strobe pops one expected word.
    always @(negedge clk) begin
        wr_t e;
        if (if_s.dram_en_wr === 1'b1) begin
            check("s_write_expected", 32'(q_s.size() != 0), 1);
            if (q_s.size() != 0) begin
                e = q_s.pop_front();
                check("s_wr_addr", 32'(if_s.addr_out), 32'(e.a));
                check("s_wr_data", if_s.data_out, e.d);
            end
        end
        if (if_r.dram_en_wr === 1'b1) begin
            check("r_write_expected", 32'(q_r.size() != 0), 1);
            if (q_r.size() != 0) begin
                e = q_r.pop_front();
                check("r_wr_addr", 32'(if_r.addr_out), 32'(e.a));
                check("r_wr_data", if_r.data_out, e.d);
            end
        end
        if (if_f.dram_en_wr === 1'b1) begin
            wr_cnt_f <= wr_cnt_f + 1;
            check("f_write_expected", 32'(q_f.size() != 0), 1);
            check("f_no_rd_during_wr", 32'(if_f.dram_en_rd), 0);
            if (q_f.size() != 0) begin
                e = q_f.pop_front();
                check("f_wr_addr", 32'(if_f.addr_out), 32'(e.a));
                check("f_wr_data", if_f.data_out, e.d);
            end
        end
        if (if_f.dram_en_rd === 1'b1 || if_f.dram_en_wr === 1'b1) rdwr_cnt_f <= rdwr_cnt_f + 1;
    end

    task automatic wait_done_s(output bit found);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (done_s === 1'b1) found = 1'b1;
            else @(negedge clk);
        end
        check("s_done_seen", 32'(found), 1);
    endtask

    task automatic small_run(input logic [31:0] a0, input logic [31:0] a1,
                             input logic [31:0] a2, input logic [31:0] a3,
                             input logic [31:0] exp);
        int k;
        int w;
        mem_s[4096] = a0; mem_s[4097] = a1; mem_s[4128] = a2; mem_s[4129] = a3;
        q_s.push_back('{18'd8192, exp});
        en_s = 1'b1;
        k = cyc;
        @(negedge clk);
        en_s = 1'b0;
        w = -1;
        for (int i = 0; i < 12 && w < 0; i++) begin
            if (if_s.dram_en_wr === 1'b1) w = cyc;
            else @(negedge clk);
        end
        check("s_wr_latency", w - k, 5);
        @(negedge clk);
        check("s_done_after_wr", 32'(done_s), 1);
        @(negedge clk);
        check("s_done_one_cycle", 32'(done_s), 0);
    endtask

    task automatic push_full(input int nwin);
        int n;
        n = 0;
        for (int c = 0; c < 6; c++)
            for (int py = 0; py < 14; py++)
                for (int px = 0; px < 14; px++) begin
                    if (n < nwin) q_f.push_back('{18'(8192 + c * 1024 + py * 32 + px), gold(c, py, px)});
                    n++;
                end
    endtask

    task automatic full_pass(input bit toggle);
        int k, w0, r0, dcyc;
        push_full(1176);
        w0 = wr_cnt_f;
        r0 = rdwr_cnt_f;
        en_f = 1'b1;
        k = cyc;
        @(negedge clk);
        check("f_first_rd_en", 32'(if_f.dram_en_rd), 1);
        check("f_first_rd_addr", 32'(if_f.addr_in), 4096);
        en_f = toggle;
        dcyc = -1;
        for (int i = 0; i < 7000 && dcyc < 0; i++) begin
            if (done_f === 1'b1) dcyc = cyc;
            else begin
                @(negedge clk);
                if (toggle) en_f = ~en_f;
            end
        end
        en_f = 1'b0;
        check("f_pass_len", dcyc - k, 5881);
        check("f_write_count", wr_cnt_f - w0, 1176);
        check("f_rdwr_cycles", rdwr_cnt_f - r0, 5880);
        @(negedge clk);
        check("f_idle_after_done", 32'({if_f.dram_en_rd, if_f.dram_en_wr, done_f}), 0);
        @(negedge clk);
        check("f_no_restart", 32'(if_f.dram_en_rd), 0);
        check("f_queue_drained", q_f.size(), 0);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        int rdn;
        int stray;
        srst = 1'b1;
        en_s = 1'b0; en_r = 1'b0; en_f = 1'b0;
        for (int c = 0; c < 6; c++)
            for (int y = 0; y < 28; y++)
                for (int x = 0; x < 28; x++)
                    mem_f[15'(rd_idx(c, y, x))] = $urandom();
        repeat (3) @(negedge clk);
        check("rst_f_strobes", 32'({if_f.dram_en_rd, if_f.dram_en_wr, done_f}), 0);
        check("rst_f_addr_in", 32'(if_f.addr_in), 0);
        check("rst_f_addr_out", 32'(if_f.addr_out), 0);
        check("rst_f_data_out", if_f.data_out, 0);
        check("rst_s_strobes", 32'({if_s.dram_en_rd, if_s.dram_en_wr, done_s}), 0);
        srst = 1'b0;
        @(negedge clk);

        // Small windows on the RELU=0 instance.
        small_run(32'd1, 32'd5, 32'hFFFF_FFFD, 32'd2, 32'd5);
        small_run(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        small_run(32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'd0, 32'h7FFF_FFFF);

        // ReLU clamp on the RELU=1 instance.
        mem_r[4096] = 32'hFFFF_FFFF; mem_r[4097] = 32'hFFFF_FFFF;
        mem_r[4128] = 32'hFFFF_FFFF; mem_r[4129] = 32'hFFFF_FFFF;
        q_r.push_back('{18'd8192, 32'd0});
        en_r = 1'b1;
        @(negedge clk);
        en_r = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (done_r === 1'b1) found = 1'b1;
            else @(negedge clk);
        end
        check("r_done_seen", 32'(found), 1);

        // Enable held high through DONE restarts only after IDLE.
        mem_s[4096] = 32'd3; mem_s[4097] = 32'hFFFF_0000; mem_s[4128] = 32'd9; mem_s[4129] = 32'd4;
        q_s.push_back('{18'd8192, 32'd9});
        q_s.push_back('{18'd8192, 32'd9});
        en_s = 1'b1;
        @(negedge clk);
        wait_done_s(found);
        @(negedge clk);
        check("s_held_idle_gap", 32'(if_s.dram_en_rd), 0);
        @(negedge clk);
        check("s_held_restart_rd", 32'(if_s.dram_en_rd), 1);
        check("s_held_restart_addr", 32'(if_s.addr_in), 4096);
        en_s = 1'b0;
        wait_done_s(found);
        @(negedge clk);

        full_pass(1'b0);

        // Reset at window 37, read d=2.
        push_full(37);
        en_f = 1'b1;
        @(negedge clk);
        en_f = 1'b0;
        rdn = 0;
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            if (if_f.dram_en_rd === 1'b1) begin
                rdn++;
                if (rdn == 151) found = 1'b1;
            end
            if (!found) @(negedge clk);
        end
        check("f_rst_point_found", 32'(found), 1);
        check("f_rst_point_addr", 32'(if_f.addr_in), 32'(rd_idx(0, 2 * 2 + 1, 2 * 9)));
        srst = 1'b1;
        @(negedge clk);
        srst = 1'b0;
        check("f_rst_strobes", 32'({if_f.dram_en_rd, if_f.dram_en_wr, done_f}), 0);
        check("f_rst_addr_in", 32'(if_f.addr_in), 0);
        check("f_rst_addr_out", 32'(if_f.addr_out), 0);
        check("f_rst_data_out", if_f.data_out, 0);
        check("f_rst_windows_written", q_f.size(), 0);
        stray = 0;
        repeat (10) begin
            @(negedge clk);
            if (if_f.dram_en_wr !== 1'b0 || if_f.dram_en_rd !== 1'b0) stray++;
        end
        check("f_quiet_after_rst", stray, 0);

        full_pass(1'b0);
        full_pass(1'b1);

        check("s_queue_empty", q_s.size(), 0);
        check("r_queue_empty", q_r.size(), 0);
        check("f_queue_empty", q_f.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pool_layer.md
# pool_layer

2x2, stride-2 max-pooling stage with optional ReLU that runs directly after `conv_layer`. It reads the convolution output feature map from the shared DRAM, reduces each 2x2 window to its signed maximum, and writes the pooled map back to a separate DRAM region. It uses the same single-port DRAM handshake style as `conv_layer`, and the top-level controller asserts `enable` once `conv_layer` raises `done`.

## Interface
- `DATA_WIDTH`, 32: data word width; signed Q16.16 two's complement.
- `ADDR_WIDTH`, 18: DRAM word-address width.
- `IFMAP_BASE`, 4096: base address of the input map (the conv output).
- `OFMAP_BASE`, 8192: base address of the pooled output.
- `IFMAP_WIDTH`, 28: input columns; must be even and ≤ 32.
- `IFMAP_HEIGHT`, 28: input rows; must be even and ≤ 32.
- `NUM_CHNL`, 6: number of channels; must be ≤ 16.
- `RELU`, 1: when 1, every output is clamped to ≥ 0.
- `clk`, input, 1: the single clock.
- `srst`, input, 1: reset. Synchronous and active-high.
- `enable`, input, 1: start request. Sampled only in IDLE.
- `dram_valid`, input, 1: present for interface compatibility with `conv_layer`. It is ignored.
- `data_in`, input, `DATA_WIDTH`: read data. It is valid exactly 1 cycle after the cycle in which `dram_en_rd`=1 presented `addr_in`.
- `data_out`, output, `DATA_WIDTH`: write data. It is 0 outside WR.
- `addr_in`, output, `ADDR_WIDTH`: read address. It is 0 outside RD.
- `addr_out`, output, `ADDR_WIDTH`: write address. It is 0 outside WR.
- `dram_en_wr`, output, 1: write strobe.
- `dram_en_rd`, output, 1: read strobe.
- `done`, output, 1: high for exactly one cycle, in DONE.

## Operation
- **FSM states:** IDLE, RD, WR, DONE.
- **IDLE:** go to RD when `enable`=1; otherwise stay in IDLE.
- **RD (4 cycles):** window offset counter `d` = 0..3 selects (dx,dy) = (0,0),(1,0),(0,1),(1,1).
  - `addr_in` = `IFMAP_BASE` + {c[3:0], (2·py+dy)[4:0], (2·px+dx)[4:0]}.
  - `dram_en_rd`=1.
  - Go to WR after d=3.
- **Running max register `mx`:** updated by the data returning in the cycle after each RD read.
  - Data for d=0 arrives in RD cycle d=1: `mx` ← `RELU` ? smax(0, `data_in`) : `data_in`.
  - Data for d=1 and d=2 arrives in RD cycles d=2 and d=3: `mx` ← smax(`mx`, `data_in`).
- **WR (1 cycle):** the d=3 data arrives in this cycle.
  - `data_out` = smax(`mx`, `data_in`), combinational.
  - `addr_out` = `OFMAP_BASE` + {c[3:0], py[4:0], px[4:0]}.
  - `dram_en_wr`=1, `dram_en_rd`=0.
- **Counter advance after WR:**
  - px increments; at px = `IFMAP_WIDTH`/2−1 it wraps to 0 and py increments.
  - At py = `IFMAP_HEIGHT`/2−1 it wraps and c increments.
  - After the last window (c = `NUM_CHNL`−1, py and px at their last values) go to DONE; otherwise go to RD.
- **DONE:** `done`=1 for one cycle, then return to IDLE. All counters are zero on re-entry to IDLE.
- **Arithmetic:** smax is a signed `DATA_WIDTH` comparison. Equal values pass the value through unchanged. No saturation and no width growth.
- **`enable` while busy:** ignored.
- **`enable` held high through DONE:** starts a new pass on the cycle after IDLE is re-entered.
- **`srst`=1 at any clock edge:**
  - State becomes IDLE; px, py, c, d and `mx` become 0.
  - All outputs become 0 from that edge on.
  - The interrupted window is not written.
- **Reset value of every output:** 0.
- **Odd dimensions:** illegal. The last row or column is never read (floor behaviour); the testbench does not rely on this.

## Timing
- From `enable` sampled in IDLE to the first RD is 1 cycle.
- Each output word takes 5 cycles (4 RD + 1 WR). Reads and writes never overlap.
- Total pass = 1 (IDLE exit) + 5·`NUM_CHNL`·(W/2)·(H/2) + 1 (DONE) cycles. With the defaults this is 5880 RD/WR cycles.
- `done` rises 1 cycle after the final WR.
- All outputs are decoded combinationally from state and registers; there is no output register.

## Structure
- **Shared package (`cnn_pkg`):** DRAM map constants (4096, 8192), address field widths (4/5/5), FSM state encodings, and an smax function shared with later stages.
- **One sub-module, `pool_addr_gen`:** the px/py/c/d counters, wrap and last flags, and both address formulas. `pool_layer` keeps the FSM, `mx` and the strobes.

## Test plan
- **Single window:** W=H=2, C=1, `RELU`=0; DRAM[4096..4097] = 1, 5; DRAM[4128..4129] = −3, 2.
  - Required: exactly one write, of 5 to address 8192, in the 5th cycle after start.
  - Required: `done` exactly 1 cycle after that write.
- **ReLU clamp:** the same window with all four values −1 and `RELU`=1.
  - Required: 0 is written.
  - Repeat with `RELU`=0: required 0xFFFF_FFFF is written.
- **Full default pass:** 6×28×28 random Q16.16 input against a golden model.
  - Required: 1176 writes, 5880 RD/WR cycles, addresses 8192 + {c, py, px}, no stray writes.
- **Tie/extremes:** window 0x7FFF_FFFF, 0x8000_0000, 0x7FFF_FFFF, 0 -> required output 0x7FFF_FFFF.
- **Reset mid-pass:** assert `srst` for 1 cycle at window 37, cycle RD d=2.
  - Required: all outputs 0 the next cycle, and no write for window 37.
  - Required: a fresh `enable` restarts at address 4096.
- **Busy enable:** toggle `enable` throughout a pass.
  - Required: identical write trace to the clean run.
  - Required: a second pass starts only after DONE→IDLE.
